// File: rtl/imem_responder.sv
// Pipelined instruction-memory responder: fixed-latency array reads drained through an in-order response FIFO.
// Latency LATENCY cycles accept-to-response; req_ready drops once RESP_DEPTH requests are outstanding.
module imem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int IMEM_SIZE     = 1024,
    parameter int LATENCY       = 2,
    parameter int RESP_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDRESS_WIDTH-1:0]     req_addr,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_WIDTH-1:0]        resp_instr,
    output logic [ADDRESS_WIDTH-1:0]     resp_addr,
    output logic                         resp_err,
    input  logic                         flush,
    input  logic                         ld_en,
    input  logic [$clog2(IMEM_SIZE)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]        ld_data
);
    localparam int IW   = $clog2(IMEM_SIZE);
    localparam int PW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW   = $clog2(RESP_DEPTH + 1);
    localparam int NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0]    mem_q [IMEM_SIZE];

    logic                     accept, pop, wr_en;
    logic                     in_err;
    logic [DATA_WIDTH-1:0]    in_instr;

    logic                     stg_vld_q  [NSTG];
    logic                     stg_err_q  [NSTG];
    logic [DATA_WIDTH-1:0]    stg_dat_q  [NSTG];
    logic [ADDRESS_WIDTH-1:0] stg_addr_q [NSTG];

    logic                     src_vld, src_err;
    logic [DATA_WIDTH-1:0]    src_dat;
    logic [ADDRESS_WIDTH-1:0] src_addr;

    logic                     fifo_err_q  [RESP_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_dat_q  [RESP_DEPTH];
    logic [ADDRESS_WIDTH-1:0] fifo_addr_q [RESP_DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_base;
    logic [CW-1:0] occ_q, occ_d, cnt_q, cnt_d;

    assign req_ready = (cnt_q < CW'(RESP_DEPTH)) && !rst;
    assign accept    = req_valid && req_ready;
    assign in_err    = (req_addr[1:0] != 2'b00) ||
                       (req_addr >= ADDRESS_WIDTH'(IMEM_SIZE * 4));
    assign in_instr  = in_err ? NOP : mem_q[req_addr[IW+1:2]];

    // Old-data-on-collision falls out of the read being taken before this edge's write lands.
    always_ff @(posedge clk) begin
        if (ld_en) mem_q[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) stg_vld_q[i] <= 1'b0;
        end else begin
            stg_vld_q[0] <= accept;
            for (int i = 1; i < NSTG; i++) stg_vld_q[i] <= stg_vld_q[i-1] && !flush;
        end
    end

    always_ff @(posedge clk) begin
        stg_err_q[0]  <= in_err;
        stg_dat_q[0]  <= in_instr;
        stg_addr_q[0] <= req_addr;
        for (int i = 1; i < NSTG; i++) begin
            stg_err_q[i]  <= stg_err_q[i-1];
            stg_dat_q[i]  <= stg_dat_q[i-1];
            stg_addr_q[i] <= stg_addr_q[i-1];
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign src_vld  = accept;
            assign src_err  = in_err;
            assign src_dat  = in_instr;
            assign src_addr = req_addr;
        end else begin : g_piped
            assign src_vld  = stg_vld_q[NSTG-1];
            assign src_err  = stg_err_q[NSTG-1];
            assign src_dat  = stg_dat_q[NSTG-1];
            assign src_addr = stg_addr_q[NSTG-1];
        end
    endgenerate

    // With LATENCY==1 the FIFO write is the flush-cycle request itself, which must survive.
    assign wr_en      = src_vld && !(flush && (LATENCY > 1));
    assign resp_valid = (occ_q != '0) && !flush && !rst;
    assign pop        = resp_valid && resp_ready;

    always_comb begin
        wr_base  = flush ? '0 : wr_ptr_q;
        wr_ptr_d = wr_base + PW'(wr_en);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
        occ_d    = flush ? CW'(wr_en) : occ_q + CW'(wr_en) - CW'(pop);
        cnt_d    = flush ? CW'(accept) : cnt_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_err_q[wr_base]  <= src_err;
            fifo_dat_q[wr_base]  <= src_dat;
            fifo_addr_q[wr_base] <= src_addr;
        end
    end

    assign resp_instr = resp_valid ? fifo_dat_q[rd_ptr_q]  : '0;
    assign resp_addr  = resp_valid ? fifo_addr_q[rd_ptr_q] : '0;
    assign resp_err   = resp_valid && fifo_err_q[rd_ptr_q];
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed cycle table, load-collision sequence, then random traffic against a queue model.
module tb_imem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int ISZ   = 1024;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_err, flush, ld_en;
    logic [31:0] req_addr, resp_instr, resp_addr, ld_data;
    logic [9:0]  ld_addr;

    always #5 clk = ~clk;

    imem_responder #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .IMEM_SIZE(ISZ), .LATENCY(LAT), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
        .resp_addr(resp_addr), .resp_err(resp_err), .flush(flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          rdy;
    } resp_t;

    typedef struct {
        logic        r, v;
        logic [31:0] a;
        logic        rr, f;
        logic        e_rdy, e_vld;
        logic [31:0] e_instr, e_addr;
        logic        e_err;
    } vec_t;

    resp_t       q[$];
    vec_t        tbl[$];
    logic [31:0] mem_m [ISZ];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        m_rdy, m_vld, m_err;
    logic [31:0] m_instr, m_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle's inputs and derive what the responder should show this cycle.
    task automatic cyc_begin(input logic r, input logic v, input logic [31:0] a, input logic rr,
                             input logic f, input logic le, input logic [9:0] la, input logic [31:0] ld);
        rst = r; req_valid = v; req_addr = a; resp_ready = rr; flush = f;
        ld_en = le; ld_addr = la; ld_data = ld;
        #3;
        m_rdy   = !r && (q.size() < DEPTH);
        m_vld   = !r && !f && (q.size() > 0) && (q[0].rdy <= cyc);
        m_instr = m_vld ? q[0].instr : 32'h0;
        m_addr  = m_vld ? q[0].addr  : 32'h0;
        m_err   = m_vld ? q[0].err   : 1'b0;
    endtask

    task automatic cyc_end();
        resp_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (m_vld && resp_ready) e = q.pop_front();
            if (flush) q.delete();
            if (req_valid && m_rdy) begin
                e.addr  = req_addr;
                e.err   = (req_addr[1:0] != 2'b00) || (req_addr >= ISZ * 4);
                e.instr = e.err ? 32'h0000_0013 : mem_m[req_addr[11:2]];
                e.rdy   = cyc + LAT;
                q.push_back(e);
            end
        end
        if (ld_en) mem_m[ld_addr] = ld_data;
        cyc++;
        #1;
    endtask

    task automatic check_model();
        chk("req_ready", {31'b0, req_ready}, {31'b0, m_rdy});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_vld});
        if (m_vld) begin
            chk("resp_instr", resp_instr, m_instr);
            chk("resp_addr", resp_addr, m_addr);
            chk("resp_err", {31'b0, resp_err}, {31'b0, m_err});
        end
    endtask

    task automatic tv(input logic r, input logic v, input logic [31:0] a, input logic rr, input logic f,
                      input logic erdy, input logic evld, input logic [31:0] ei, input logic [31:0] ea,
                      input logic ee);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.rr = rr; t.f = f;
        t.e_rdy = erdy; t.e_vld = evld; t.e_instr = ei; t.e_addr = ea; t.e_err = ee;
        tbl.push_back(t);
    endtask

    task automatic idle(input logic rr);
        cyc_begin(1'b0, 1'b0, 32'h0, rr, 1'b0, 1'b0, 10'h0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [9:0]  la;

        // Reset values
        cyc_begin(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_instr", resp_instr, 32'h0);
        chk("rst_resp_addr", resp_addr, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        cyc_end();
        idle(1'b1);
        chk("ready_after_rst", {31'b0, req_ready}, 32'h1);
        cyc_end();

        for (int i = 0; i < ISZ; i++) begin
            cyc_begin(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'(i), $urandom);
            cyc_end();
        end
        for (int i = 0; i < 4; i++) begin
            cyc_begin(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'(i), 32'h1000_0000 + i);
            cyc_end();
        end
        cyc_begin(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF);   cyc_end();
        cyc_begin(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'd16, 32'h4040_4040);  cyc_end();

        // r  v  addr          rr f   rdy vld instr           addr          err
        tv(0, 1, 32'h14,       1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'hDEAD_BEEF,  32'h14,       0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h4,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h8,        1, 0,  1,  1,  32'h1000_0000,  32'h0,        0);
        tv(0, 1, 32'hC,        1, 0,  1,  1,  32'h1000_0001,  32'h4,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'h1000_0002,  32'h8,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'h1000_0003,  32'hC,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h0,        0, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h4,        0, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h8,        0, 0,  1,  1,  32'h1000_0000,  32'h0,        0);
        tv(0, 1, 32'hC,        0, 0,  1,  1,  32'h1000_0000,  32'h0,        0);
        tv(0, 1, 32'h10,       0, 0,  0,  1,  32'h1000_0000,  32'h0,        0);
        tv(0, 1, 32'h14,       0, 0,  0,  1,  32'h1000_0000,  32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  0,  1,  32'h1000_0000,  32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'h1000_0001,  32'h4,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'h1000_0002,  32'h8,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'h1000_0003,  32'hC,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h6,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h1000,     1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'h13,         32'h6,        1);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'h13,         32'h1000,     1);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h0,        0, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h4,        0, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h8,        0, 0,  1,  1,  32'h1000_0000,  32'h0,        0);
        tv(0, 1, 32'h40,       0, 1,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  1,  32'h4040_4040,  32'h40,       0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 1, 32'h4,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(1, 0, 32'h0,        1, 0,  0,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);
        tv(0, 0, 32'h0,        1, 0,  1,  0,  32'h0,          32'h0,        0);

        foreach (tbl[i]) begin
            cyc_begin(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].rr, tbl[i].f, 1'b0, 10'h0, 32'h0);
            chk($sformatf("tbl%0d_req_ready", i), {31'b0, req_ready}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_resp_valid", i), {31'b0, resp_valid}, {31'b0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_resp_instr", i), resp_instr, tbl[i].e_instr);
                chk($sformatf("tbl%0d_resp_addr", i), resp_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d_resp_err", i), {31'b0, resp_err}, {31'b0, tbl[i].e_err});
            end
            cyc_end();
        end

        // Load and fetch of the same word in one cycle returns the pre-load data.
        cyc_begin(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'd7, 32'h7777_0000);  cyc_end();
        cyc_begin(1'b0, 1'b1, 32'h1C, 1'b1, 1'b0, 1'b1, 10'd7, 32'h7777_1111); cyc_end();
        idle(1'b1); cyc_end();
        idle(1'b1);
        chk("rdw_old_valid", {31'b0, resp_valid}, 32'h1);
        chk("rdw_old_instr", resp_instr, 32'h7777_0000);
        cyc_end();
        cyc_begin(1'b0, 1'b1, 32'h1C, 1'b1, 1'b0, 1'b0, 10'd0, 32'h0); cyc_end();
        idle(1'b1); cyc_end();
        idle(1'b1);
        chk("rdw_new_valid", {31'b0, resp_valid}, 32'h1);
        chk("rdw_new_instr", resp_instr, 32'h7777_1111);
        cyc_end();

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 19))
                0:       a = $urandom;
                1:       a = {20'h0, $urandom_range(0, 1023) << 2} + 32'($urandom_range(1, 3));
                2:       a = 32'h1000 + ($urandom_range(0, 255) << 2);
                default: a = {20'h0, 12'($urandom_range(0, 1023) << 2)};
            endcase
            la = ($urandom_range(0, 1) == 0) ? a[11:2] : 10'($urandom_range(0, 1023));
            cyc_begin($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, a,
                      $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 4) == 0, la, $urandom);
            check_model();
            cyc_end();
        end
        for (int n = 0; n < 8; n++) begin
            idle(1'b1);
            check_model();
            cyc_end();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Pipelined instruction-memory responder at the far end of the fetch interface. Accepts word fetch requests over a valid/ready channel, returns instruction words after a fixed read latency through an in-order response FIFO, and flags misaligned or out-of-range fetches. A flush input discards all in-flight and buffered responses when the pipeline redirects on a taken branch or jump. A load port writes the array for program loading.

## Interface
- DATA_WIDTH, 32: instruction word width
- ADDRESS_WIDTH, 32: byte address width
- IMEM_SIZE, 1024: array depth in words, power of two
- LATENCY, 2: accept-to-response cycles, legal 1..4
- RESP_DEPTH, 4: max outstanding requests (in flight + buffered), power of two, >= LATENCY
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDRESS_WIDTH  byte address of the fetch
- resp_valid  out  1  response at FIFO head valid
- resp_ready  in  1  consumer takes the response
- resp_instr  out  DATA_WIDTH  instruction word
- resp_addr  out  ADDRESS_WIDTH  byte address echoed from the request
- resp_err  out  1  misaligned or out-of-range fetch
- flush  in  1  discard all in-flight and buffered responses
- ld_en  in  1  load-port write enable
- ld_addr  in  log2(IMEM_SIZE)  load word address
- ld_data  in  DATA_WIDTH  load word data

## Operation
- Accept when req_valid && req_ready. Array read uses word index req_addr[log2(IMEM_SIZE)+1:2], sampled in the accept cycle.
- Error when req_addr[1:0] != 0 or req_addr >= IMEM_SIZE*4: resp_err=1, resp_instr=32'h00000013 (NOP), array not read.
- Read data and address pass through a LATENCY-deep valid-tagged pipeline into a RESP_DEPTH-entry FIFO. Responses leave strictly in request order.
- Outstanding counter: +1 on accept, -1 on pop (resp_valid && resp_ready). req_ready = (count < RESP_DEPTH) && !rst. The FIFO can therefore never overflow.
- Flush cycle: all pipeline valid bits and the FIFO clear at the edge. resp_valid is forced 0 in that cycle, so no pop can occur. count becomes 1 if a request is accepted in the same cycle, else 0. A request accepted in the flush cycle survives as the redirect target.
- Load port: ld_en writes ld_data at ld_addr at the edge. A fetch of the same word in the same cycle returns the old data. The load port works regardless of traffic.
- Array contents are not reset.

## Timing
- Reset values: req_ready=0 during rst, 1 in the first cycle after; resp_valid=0; resp_instr=0; resp_addr=0; resp_err=0; count=0; FIFO empty; pipeline valids 0.
- Reset mid-operation drops all outstanding requests. No response is emitted for them.
- Latency: a request accepted in cycle t with nothing older pending gives resp_valid=1 in cycle t+LATENCY.
- Throughput: one request per cycle while resp_ready=1 and count < RESP_DEPTH.
- resp_valid, resp_instr, resp_addr and resp_err hold stable while resp_valid && !resp_ready. They change only after a pop or a flush.
- Accept and pop in the same cycle leaves count unchanged. At count == RESP_DEPTH, a pop re-enables req_ready in the next cycle, not combinationally.
- FIFO pointers wrap modulo RESP_DEPTH. Full and empty are distinguished by occupancy, not pointer equality.

## Test plan
- LATENCY=2: after loading word 5 = 32'hDEADBEEF, request addr 0x14 at cycle 10 -> resp_valid=1 at cycle 12, resp_instr=32'hDEADBEEF, resp_addr=0x14, resp_err=0.
- Back-to-back requests 0x0, 0x4, 0x8, 0xC with resp_ready=1 -> four responses on consecutive cycles, in order, with req_ready held at 1.
- resp_ready=0, issue 6 requests -> exactly 4 accepted, then req_ready=0. Raise resp_ready -> 4 in-order responses, then req_ready=1.
- Request 0x6 (misaligned), then 0x1000 (out of range with IMEM_SIZE=1024) -> both responses have resp_err=1 and resp_instr=32'h00000013.
- 3 requests outstanding, assert flush together with a request to 0x40 -> old responses never appear; exactly one response follows, resp_addr=0x40, LATENCY cycles later.
- Assert rst for one cycle with 2 requests in flight -> resp_valid stays 0, req_ready=0 during rst and 1 the next cycle, no stale response ever appears.
